// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle add/sub/logic/shift ops, iterative shift-add MUL
// and restoring DIVU (one bit per cycle), registered result/flags with done pulse.
module alu_mc #(
   parameter int DATA_WIDTH  = 16,
   parameter int SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  valid_i,
   output logic                  ready_o,
   input  logic [3:0]            op_i,
   input  logic [DATA_WIDTH-1:0] a_i,
   input  logic [DATA_WIDTH-1:0] b_i,
   input  logic [3:0]            psr_i,
   output logic                  done_o,
   output logic [DATA_WIDTH-1:0] result_o,
   output logic [3:0]            apsr_o
);

   localparam int W  = DATA_WIDTH;
   localparam int CW = $clog2(DATA_WIDTH);

   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,  OP_ADDC = 4'd1,  OP_SUB  = 4'd2,  OP_SUBC = 4'd3,
      OP_NAND = 4'd4,  OP_NOR  = 4'd5,  OP_XOR  = 4'd6,  OP_XNOR = 4'd7,
      OP_SHL  = 4'd8,  OP_SHR  = 4'd9,  OP_ASR  = 4'd10, OP_MUL  = 4'd11,
      OP_DIVU = 4'd12
   } op_t;

   state_t          state, nxt_state;
   logic            accept, multi, last;
   logic [CW-1:0]   cnt;
   logic [W-1:0]    hi, lo, opnd;
   logic            is_div;

   logic [W-1:0]    s_res;
   logic            s_v, s_c, s_pass;
   logic [3:0]      s_flags;
   logic [W:0]      wide;
   logic [SHAMT_WIDTH-1:0] sh;

   logic [W:0]      it_sum;
   logic [W-1:0]    it_hi, it_lo;
   logic [3:0]      fin_flags;

   assign ready_o = (state != EXEC) && !rst_i;
   assign accept  = valid_i && ready_o;
   assign multi   = (op_i == OP_MUL) || (op_i == OP_DIVU);
   assign last    = (cnt == CW'(W - 1));
   assign sh      = b_i[SHAMT_WIDTH-1:0];

   always_ff @(posedge clk_i) begin
      if (rst_i) state <= IDLE;
      else       state <= nxt_state;
   end

   always_comb begin
      nxt_state = state;
      case (state)
         IDLE, DONE: begin
            if (accept) nxt_state = multi ? EXEC : DONE;
            else        nxt_state = IDLE;
         end
         EXEC: if (last) nxt_state = DONE;
         default: nxt_state = IDLE;
      endcase
   end

   always_comb begin
      s_res  = a_i;
      s_v    = 1'b0;
      s_c    = 1'b0;
      s_pass = 1'b0;
      wide   = '0;
      case (op_i)
         OP_ADD, OP_ADDC: begin
            wide  = {1'b0, a_i} + {1'b0, b_i} + (W+1)'((op_i == OP_ADDC) && psr_i[0]);
            s_res = wide[W-1:0];
            s_c   = wide[W];
            s_v   = (a_i[W-1] == b_i[W-1]) && (s_res[W-1] != a_i[W-1]);
         end
         OP_SUB, OP_SUBC: begin
            // Top bit of the extended difference is the unsigned borrow.
            wide  = {1'b0, a_i} - {1'b0, b_i} - (W+1)'((op_i == OP_SUBC) && psr_i[0]);
            s_res = wide[W-1:0];
            s_c   = wide[W];
            s_v   = (a_i[W-1] != b_i[W-1]) && (s_res[W-1] != a_i[W-1]);
         end
         OP_NAND: s_res = ~(a_i & b_i);
         OP_NOR:  s_res = ~(a_i | b_i);
         OP_XOR:  s_res = a_i ^ b_i;
         OP_XNOR: s_res = ~(a_i ^ b_i);
         OP_SHL: begin
            wide  = {1'b0, a_i} << sh;
            s_res = wide[W-1:0];
            s_c   = wide[W];
         end
         OP_SHR: begin
            wide  = {a_i, 1'b0} >> sh;
            s_res = wide[W:1];
            s_c   = wide[0];
         end
         OP_ASR: begin
            wide  = $signed({a_i, 1'b0}) >>> sh;
            s_res = wide[W:1];
            s_c   = wide[0];
         end
         OP_MUL, OP_DIVU: s_res = a_i;
         default: s_pass = 1'b1;
      endcase
      if (s_pass) s_flags = psr_i;
      else        s_flags = {s_v, s_res[W-1], (s_res == '0), s_c};
   end

   // MUL: hi:lo is the product shifting right; DIVU: hi is the remainder, lo
   // shifts the dividend out at the top and quotient bits in at the bottom.
   always_comb begin
      it_sum = '0;
      if (is_div) begin
         it_sum = {hi, lo[W-1]} - {1'b0, opnd};
         if (!it_sum[W]) begin
            it_hi = it_sum[W-1:0];
            it_lo = {lo[W-2:0], 1'b1};
         end else begin
            it_hi = {hi[W-2:0], lo[W-1]};
            it_lo = {lo[W-2:0], 1'b0};
         end
         fin_flags = {(opnd == '0), it_lo[W-1], (it_lo == '0), 1'b0};
      end else begin
         it_sum    = lo[0] ? ({1'b0, hi} + {1'b0, opnd}) : {1'b0, hi};
         it_hi     = it_sum[W:1];
         it_lo     = {it_sum[0], lo[W-1:1]};
         fin_flags = {1'b0, it_lo[W-1], (it_lo == '0), (it_hi != '0)};
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         done_o   <= 1'b0;
         result_o <= '0;
         apsr_o   <= '0;
         cnt      <= '0;
         hi       <= '0;
         lo       <= '0;
         opnd     <= '0;
         is_div   <= 1'b0;
      end else begin
         done_o <= 1'b0;
         if (accept) begin
            if (multi) begin
               is_div <= (op_i == OP_DIVU);
               cnt    <= '0;
               hi     <= '0;
               lo     <= (op_i == OP_DIVU) ? a_i : b_i;
               opnd   <= (op_i == OP_DIVU) ? b_i : a_i;
            end else begin
               result_o <= s_res;
               apsr_o   <= s_flags;
               done_o   <= 1'b1;
            end
         end else if (state == EXEC) begin
            cnt <= cnt + 1'b1;
            hi  <= it_hi;
            lo  <= it_lo;
            if (last) begin
               result_o <= it_lo;
               apsr_o   <= fin_flags;
               done_o   <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_alu_mc.sv
// Directed-vector bench for alu_mc at DATA_WIDTH=16; expected values hand-computed.
module tb_alu_mc;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        valid_i;
   logic        ready_o;
   logic [3:0]  op_i;
   logic [15:0] a_i, b_i;
   logic [3:0]  psr_i;
   logic        done_o;
   logic [15:0] result_o;
   logic [3:0]  apsr_o;

   int unsigned total = 0;
   int unsigned bad   = 0;

   alu_mc #(.DATA_WIDTH(16)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
      .op_i(op_i), .a_i(a_i), .b_i(b_i), .psr_i(psr_i),
      .done_o(done_o), .result_o(result_o), .apsr_o(apsr_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Issue one request, check busy cycles, the done pulse with result/flags,
   // and that done drops again afterwards.
   task automatic run_op(input string tag, input logic [3:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [3:0] psr,
                         input logic [15:0] er, input logic [3:0] ea, input int lat);
      @(negedge clk_i);
      op_i = op; a_i = a; b_i = b; psr_i = psr; valid_i = 1'b1;
      chk({tag, "_rdy"}, 32'(ready_o), 32'd1);
      @(posedge clk_i);
      #1 valid_i = 1'b0;
      for (int i = 1; i < lat; i++) begin
         @(negedge clk_i);
         chk({tag, "_busy"}, {30'd0, ready_o, done_o}, 32'b00);
      end
      @(negedge clk_i);
      chk({tag, "_done"}, 32'(done_o), 32'd1);
      chk({tag, "_res"}, 32'(result_o), 32'(er));
      chk({tag, "_apsr"}, 32'(apsr_o), 32'(ea));
      @(negedge clk_i);
      chk({tag, "_pulse"}, 32'(done_o), 32'd0);
      chk({tag, "_hold"}, 32'(result_o), 32'(er));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_i = 1'b1; valid_i = 1'b0; op_i = '0; a_i = '0; b_i = '0; psr_i = '0;
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      chk("rst_done", 32'(done_o), 32'd0);
      chk("rst_res", 32'(result_o), 32'd0);
      chk("rst_apsr", 32'(apsr_o), 32'd0);
      chk("rst_rdy", 32'(ready_o), 32'd0);
      rst_i = 1'b0;
      #1 chk("rel_rdy", 32'(ready_o), 32'd1);

      //              tag      op     a         b         psr      result    {V,N,Z,C} lat
      run_op("add",   4'd0,  16'hFFFF, 16'h0001, 4'b0000, 16'h0000, 4'b0011, 1);
      run_op("addc",  4'd1,  16'h7FFF, 16'h0000, 4'b0001, 16'h8000, 4'b1100, 1);
      run_op("sub",   4'd2,  16'h8000, 16'h0001, 4'b0000, 16'h7FFF, 4'b1000, 1);
      run_op("subc",  4'd3,  16'h0000, 16'h0000, 4'b0001, 16'hFFFF, 4'b0101, 1);
      run_op("nand",  4'd4,  16'hF0F0, 16'hFF00, 4'b1111, 16'h0FFF, 4'b0000, 1);
      run_op("nor",   4'd5,  16'h00F0, 16'h0F00, 4'b0000, 16'hF00F, 4'b0100, 1);
      run_op("xor",   4'd6,  16'hAAAA, 16'h5555, 4'b0000, 16'hFFFF, 4'b0100, 1);
      run_op("xnor",  4'd7,  16'hAAAA, 16'h5555, 4'b0000, 16'h0000, 4'b0010, 1);
      run_op("shl0",  4'd8,  16'h1234, 16'h0000, 4'b0001, 16'h1234, 4'b0000, 1);
      run_op("shl4",  4'd8,  16'h1234, 16'h0004, 4'b0000, 16'h2340, 4'b0001, 1);
      run_op("shr",   4'd9,  16'h0003, 16'h0001, 4'b0000, 16'h0001, 4'b0001, 1);
      run_op("asr",   4'd10, 16'h8001, 16'h0001, 4'b0000, 16'hC000, 4'b0101, 1);
      run_op("pass",  4'd13, 16'h1357, 16'hFFFF, 4'b1010, 16'h1357, 4'b1010, 1);
      run_op("mul",   4'd11, 16'h0100, 16'h0100, 4'b0000, 16'h0000, 4'b0011, 17);
      run_op("mul15", 4'd11, 16'h0003, 16'h0005, 4'b0000, 16'h000F, 4'b0000, 17);
      run_op("mulff", 4'd11, 16'hFFFF, 16'hFFFF, 4'b0000, 16'h0001, 4'b0001, 17);
      run_op("divu",  4'd12, 16'd100,  16'd7,    4'b0000, 16'h000E, 4'b0000, 17);
      run_op("div0",  4'd12, 16'd5,    16'd0,    4'b0000, 16'hFFFF, 4'b1100, 17);
      run_op("divbig",4'd12, 16'hFFFF, 16'h0010, 4'b0000, 16'h0FFF, 4'b0000, 17);

      // Reset in the middle of a MUL aborts it without a done pulse.
      @(negedge clk_i);
      op_i = 4'd11; a_i = 16'h0003; b_i = 16'h0005; valid_i = 1'b1;
      @(posedge clk_i);
      #1 valid_i = 1'b0;
      repeat (4) @(negedge clk_i);
      rst_i = 1'b1;
      @(negedge clk_i);
      chk("abort_rdy", 32'(ready_o), 32'd0);
      chk("abort_res", 32'(result_o), 32'd0);
      chk("abort_apsr", 32'(apsr_o), 32'd0);
      rst_i = 1'b0;
      begin
         int unsigned seen = 0;
         for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            if (done_o) seen++;
         end
         chk("abort_nodone", 32'(seen), 32'd0);
      end
      run_op("post", 4'd0, 16'h0001, 16'h0002, 4'b0000, 16'h0003, 4'b0000, 1);

      // Back-to-back: XOR issued in the DONE cycle of an ADD.
      @(negedge clk_i);
      op_i = 4'd0; a_i = 16'h0010; b_i = 16'h0020; psr_i = '0; valid_i = 1'b1;
      @(posedge clk_i);
      #1 op_i = 4'd6; a_i = 16'h00FF; b_i = 16'h0F0F;
      @(negedge clk_i);
      chk("b2b_d1", 32'(done_o), 32'd1);
      chk("b2b_r1", 32'(result_o), 32'h0030);
      chk("b2b_rdy", 32'(ready_o), 32'd1);
      @(posedge clk_i);
      #1 valid_i = 1'b0;
      @(negedge clk_i);
      chk("b2b_d2", 32'(done_o), 32'd1);
      chk("b2b_r2", 32'(result_o), 32'h0FF0);
      @(negedge clk_i);
      chk("b2b_end", 32'(done_o), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
